// File: rtl/fpmul_pkg.sv
// Shared types and helpers for the FP multiplier pipeline: operand classes,
// exception flag bundle, and exponent-field predicates.
package fpmul_pkg;

    localparam int unsigned MAX_EXP_W = 16;

    typedef enum logic [1:0] {
        CLS_NORM,
        CLS_ZERO,
        CLS_INF,
        CLS_NAN
    } fp_cls_e;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
    } fp_flags_t;

    // Exponent is passed zero-extended to MAX_EXP_W; only the low w bits are significant.
    function automatic logic exp_all_ones(input logic [MAX_EXP_W-1:0] e, input int unsigned w);
        logic r;
        r = 1'b1;
        for (int unsigned i = 0; i < MAX_EXP_W; i++) begin
            if (i < w && !e[i]) r = 1'b0;
        end
        return r;
    endfunction

    function automatic logic exp_zero(input logic [MAX_EXP_W-1:0] e);
        return (e == '0);
    endfunction

endpackage

// File: rtl/fpmul_unpack_lane.sv
// Combinational operand unpacker: packed FP word -> sign, exponent, significand, class.
// Denormal handling selected by FPMUL_DENORM_EN (defined: keep denormals, else flush to zero).
module fpmul_unpack_lane
    import fpmul_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] fp,
    output logic                 sign,
    output logic [EXP_W-1:0]     exp,
    output logic [MAN_W:0]       sig,
    output fp_cls_e              cls
);

    logic [EXP_W-1:0]     exp_f;
    logic [MAN_W-1:0]     man_f;
    logic [MAX_EXP_W-1:0] exp_ext;

    assign sign    = fp[EXP_W+MAN_W];
    assign exp_f   = fp[EXP_W+MAN_W-1:MAN_W];
    assign man_f   = fp[MAN_W-1:0];
    assign exp_ext = {{(MAX_EXP_W-EXP_W){1'b0}}, exp_f};

    always_comb begin
        exp = exp_f;
        sig = {1'b1, man_f};
        cls = CLS_NORM;
        if (exp_all_ones(exp_ext, EXP_W)) begin
            cls = (man_f == '0) ? CLS_INF : CLS_NAN;
        end else if (exp_zero(exp_ext)) begin
            if (man_f == '0) begin
                exp = '0;
                sig = '0;
                cls = CLS_ZERO;
            end else begin
`ifdef FPMUL_DENORM_EN
                // Denormal: true exponent equals that of the smallest normal, no hidden bit.
                exp = EXP_W'(1);
                sig = {1'b0, man_f};
                cls = CLS_NORM;
`else
                exp = '0;
                sig = '0;
                cls = CLS_ZERO;
`endif
            end
        end
    end

endmodule

// File: rtl/fpmul_unpack_stage.sv
// FP multiplier stage 1: unpack both operands, combine sign and exception flags,
// and register the result behind a valid/ready handshake with a 2-entry skid buffer.
module fpmul_unpack_stage
    import fpmul_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   fp_a,
    input  logic [EXP_W+MAN_W:0]   fp_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W-1:0]       a_exp,
    output logic [MAN_W:0]         a_sig,
    output logic [EXP_W-1:0]       b_exp,
    output logic [MAN_W:0]         b_sig,
    output logic                   sign_out,
    output logic                   is_nan,
    output logic                   is_inf,
    output logic                   is_zero
);

    localparam int unsigned FP_W = 1 + EXP_W + MAN_W;

    typedef struct packed {
        logic [EXP_W-1:0] a_exp;
        logic [MAN_W:0]   a_sig;
        logic [EXP_W-1:0] b_exp;
        logic [MAN_W:0]   b_sig;
        logic             sign;
        fp_flags_t        flags;
    } res_t;

    typedef enum logic [1:0] {
        SK_EMPTY,
        SK_ONE,
        SK_TWO
    } skid_e;

    logic             a_sign, b_sign;
    logic [EXP_W-1:0] a_exp_w, b_exp_w;
    logic [MAN_W:0]   a_sig_w, b_sig_w;
    fp_cls_e          a_cls, b_cls;

    fpmul_unpack_lane #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_lane_a (
        .fp   (fp_a[FP_W-1:0]),
        .sign (a_sign),
        .exp  (a_exp_w),
        .sig  (a_sig_w),
        .cls  (a_cls)
    );

    fpmul_unpack_lane #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_lane_b (
        .fp   (fp_b[FP_W-1:0]),
        .sign (b_sign),
        .exp  (b_exp_w),
        .sig  (b_sig_w),
        .cls  (b_cls)
    );

    res_t new_res;

    always_comb begin
        logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        a_nan  = (a_cls == CLS_NAN);
        b_nan  = (b_cls == CLS_NAN);
        a_inf  = (a_cls == CLS_INF);
        b_inf  = (b_cls == CLS_INF);
        a_zero = (a_cls == CLS_ZERO);
        b_zero = (b_cls == CLS_ZERO);

        new_res       = '0;
        new_res.a_exp = a_exp_w;
        new_res.a_sig = a_sig_w;
        new_res.b_exp = b_exp_w;
        new_res.b_sig = b_sig_w;
        new_res.sign  = a_sign ^ b_sign;
        // One-hot-or-none flags: NaN (incl. inf*0) beats inf beats zero.
        new_res.flags.nan  = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
        new_res.flags.inf  = ~new_res.flags.nan & (a_inf | b_inf);
        new_res.flags.zero = ~new_res.flags.nan & ~new_res.flags.inf & (a_zero | b_zero);
    end

    skid_e state_q, state_d;
    res_t  out_q, out_d;
    res_t  skid_q, skid_d;
    logic  out_valid_q, out_valid_d;
    logic  in_ready_q, in_ready_d;
    logic  accept, pop;

    assign accept = in_valid & in_ready_q;
    assign pop    = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        unique case (state_q)
            SK_EMPTY: begin
                if (accept) begin
                    out_d   = new_res;
                    state_d = SK_ONE;
                end
            end
            SK_ONE: begin
                if (accept && pop) begin
                    out_d = new_res;
                end else if (accept) begin
                    skid_d  = new_res;
                    state_d = SK_TWO;
                end else if (pop) begin
                    state_d = SK_EMPTY;
                end
            end
            SK_TWO: begin
                if (pop) begin
                    out_d   = skid_q;
                    state_d = SK_ONE;
                end
            end
            default: state_d = SK_EMPTY;
        endcase
        out_valid_d = (state_d != SK_EMPTY);
        in_ready_d  = (state_d != SK_TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SK_EMPTY;
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign a_exp     = out_q.a_exp;
    assign a_sig     = out_q.a_sig;
    assign b_exp     = out_q.b_exp;
    assign b_sig     = out_q.b_sig;
    assign sign_out  = out_q.sign;
    assign is_nan    = out_q.flags.nan;
    assign is_inf    = out_q.flags.inf;
    assign is_zero   = out_q.flags.zero;

endmodule
